// File: rtl/scaled_frame_buffer.sv
// Ping-pong capture buffer for 8x8 scaled frames from the 2x2 scaler.
// Write side fills one bank while the read FSM streams the other bank out
// over valid/ready with row/col tags. A per-frame pixel sum is published
// when each capture completes. Pixels that arrive while both banks are
// occupied are dropped and latched into a sticky overflow flag.
module scaled_frame_buffer #(
  parameter int PIX_W     = 8,
  parameter int ROW_LEN   = 8,
  parameter int FRAME_PIX = 64,
  parameter int SUM_W     = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic [PIX_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [2:0]       out_row,
  output logic [2:0]       out_col,
  output logic [SUM_W-1:0] frame_sum,
  output logic             sum_valid,
  output logic             overflow
);

  localparam int CNT_W = $clog2(FRAME_PIX);

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       bank_full_q, bank_full_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [SUM_W-1:0] frame_sum_q, frame_sum_d;
  logic             sum_valid_q, sum_valid_d;
  logic             overflow_q, overflow_d;

  // Both banks live in one array; the bank select is the address MSB.
  logic [PIX_W-1:0] mem_q [2*FRAME_PIX];

  logic             wr_accept, wr_drop, wr_done;
  logic             rd_xfer, rd_last, rd_done;
  logic [SUM_W-1:0] acc_sum;

  // A pixel is only taken when the bank it targets is free as of this cycle;
  // a release by the reader on the same edge does not rescue it.
  assign wr_accept = pix_valid & ~bank_full_q[wr_bank_q];
  assign wr_drop   = pix_valid &  bank_full_q[wr_bank_q];
  assign wr_done   = wr_accept & (wr_cnt_q == CNT_W'(FRAME_PIX - 1));
  assign acc_sum   = acc_q + SUM_W'(pix_in);

  assign rd_xfer   = (state_q == ST_SEND) & out_ready;
  assign rd_last   = (rd_cnt_q == CNT_W'(FRAME_PIX - 1));
  assign rd_done   = rd_xfer & rd_last;

  // Write-side next state: counter, bank toggle, running sum, overflow.
  always_comb begin
    wr_cnt_d    = wr_cnt_q;
    wr_bank_d   = wr_bank_q;
    acc_d       = acc_q;
    frame_sum_d = frame_sum_q;
    sum_valid_d = 1'b0;
    overflow_d  = overflow_q | wr_drop;
    if (wr_accept) begin
      if (wr_done) begin
        wr_cnt_d    = '0;
        wr_bank_d   = ~wr_bank_q;
        acc_d       = '0;
        frame_sum_d = acc_sum;
        sum_valid_d = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
        acc_d    = acc_sum;
      end
    end
  end

  // Read-side next state: counter and bank toggle on each transfer.
  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    if (rd_xfer) begin
      if (rd_last) begin
        rd_cnt_d  = '0;
        rd_bank_d = ~rd_bank_q;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end
  end

  // Bank ownership: writer completion and reader release always hit different banks.
  always_comb begin
    bank_full_d = bank_full_q;
    if (rd_done) bank_full_d[rd_bank_q] = 1'b0;
    if (wr_done) bank_full_d[wr_bank_q] = 1'b1;
  end

  // Read FSM next state; the return to IDLE forces one gap cycle between frames.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bank_full_q[rd_bank_q]) state_d = ST_SEND;
      ST_SEND: if (rd_done)                state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read FSM outputs; everything is forced to zero outside SEND.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_row   = '0;
    out_col   = '0;
    if (state_q == ST_SEND) begin
      out_valid = 1'b1;
      out_data  = mem_q[{rd_bank_q, rd_cnt_q}];
      out_last  = rd_last;
      out_row   = 3'(rd_cnt_q / CNT_W'(ROW_LEN));
      out_col   = 3'(rd_cnt_q % CNT_W'(ROW_LEN));
    end
  end

  // Control and datapath state registers, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      bank_full_q <= '0;
      acc_q       <= '0;
      frame_sum_q <= '0;
      sum_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      bank_full_q <= bank_full_d;
      acc_q       <= acc_d;
      frame_sum_q <= frame_sum_d;
      sum_valid_q <= sum_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  // Pixel storage; contents are never cleared, stale data is never read.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[{wr_bank_q, wr_cnt_q}] <= pix_in;
  end

  assign frame_sum = frame_sum_q;
  assign sum_valid = sum_valid_q;
  assign overflow  = overflow_q;

endmodule
